// File: rtl/display_mux_7seg.sv
// rtl/display_mux_7seg.sv - 4-digit multiplexed 7-segment display driver
//
// Scans a 4-digit common-anode display one digit per rising scan_clk edge.
// It decodes BCD or hex digits, suppresses leading zeros, and supports
// per-digit decimal points and per-digit blinking.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   scan_clk   scan square wave (asynchronous level)
//   blink_clk  blink square wave (asynchronous level)
//   data_in    four nibbles, [3:0] = digit 0 (rightmost)
//   dp_mask    decimal point enable per digit
//   blink_mask blink enable per digit
//   lz_en      leading-zero suppression enable
//   seg_n      segments g..a, active-low
//   dp_n       decimal point, active-low
//   an_n       digit anodes, active-low
//   frame_done one-cycle pulse when the digit index wraps 3->0
module display_mux_7seg #(
   parameter int BLANK_CYCLES = 64,
   parameter bit HEX_MODE     = 1'b1,
   parameter int CNT_W        = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        scan_clk,
   input  logic        blink_clk,
   input  logic [15:0] data_in,
   input  logic [3:0]  dp_mask,
   input  logic [3:0]  blink_mask,
   input  logic        lz_en,
   output logic [6:0]  seg_n,
   output logic        dp_n,
   output logic [3:0]  an_n,
   output logic        frame_done
);

   typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic             scan_q1, scan_q2, scan_q3;
   logic             blink_q1, blink_q2;
   logic [15:0]      data_q;
   logic [3:0]       dp_mask_q, blink_mask_q;
   logic             lz_q;
   logic             valid_q;
   logic [6:0]       seg_n_q, seg_n_d;
   logic             dp_n_q, dp_n_d;
   logic [3:0]       an_n_q, an_n_d;
   logic             frame_done_q;

   logic             step, wrap, blink_on, dark;
   logic [3:0]       nibble;
   logic [3:0]       zero_from;

   assign step     = scan_q2 & ~scan_q3;
   assign wrap     = step && (idx_q == 2'd3);
   assign blink_on = blink_q2;

   function automatic logic [6:0] decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = HEX_MODE ? 7'h08 : 7'h3F;
         4'hB: s = HEX_MODE ? 7'h03 : 7'h3F;
         4'hC: s = HEX_MODE ? 7'h46 : 7'h3F;
         4'hD: s = HEX_MODE ? 7'h21 : 7'h3F;
         4'hE: s = HEX_MODE ? 7'h06 : 7'h3F;
         default: s = HEX_MODE ? 7'h0E : 7'h3F;
      endcase
      return s;
   endfunction

   always_comb begin
      case (idx_q)
         2'd0:    nibble = data_q[3:0];
         2'd1:    nibble = data_q[7:4];
         2'd2:    nibble = data_q[11:8];
         default: nibble = data_q[15:12];
      endcase
   end

   // zero_from[i]: nibble i and every higher nibble are zero; digit 0 is never hidden.
   always_comb begin
      zero_from[3] = (data_q[15:12] == 4'h0);
      zero_from[2] = zero_from[3] && (data_q[11:8] == 4'h0);
      zero_from[1] = zero_from[2] && (data_q[7:4] == 4'h0);
      zero_from[0] = 1'b0;
   end

   // Nothing is shown until the first wrap has loaded the shadows.
   assign dark = !valid_q || (lz_q && zero_from[idx_q]) ||
                 (blink_on && blink_mask_q[idx_q]);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      if (step) begin
         state_d = ST_BLANK;
         cnt_d   = CNT_W'(BLANK_CYCLES);
         idx_d   = idx_q + 2'd1;
      end else if (state_q == ST_BLANK) begin
         if (cnt_q == '0) state_d = ST_DRIVE;
         else             cnt_d   = cnt_q - 1'b1;
      end
   end

   // Outputs are registered from the next state, so the dark interval
   // covers exactly the BLANK state and the digit appears on entry to DRIVE.
   always_comb begin
      an_n_d  = 4'hF;
      seg_n_d = 7'h7F;
      dp_n_d  = 1'b1;
      if (state_d == ST_DRIVE && !dark) begin
         an_n_d  = ~(4'b0001 << idx_q);
         seg_n_d = decode(nibble);
         dp_n_d  = ~dp_mask_q[idx_q];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_BLANK;
         cnt_q        <= '0;
         idx_q        <= 2'd0;
         scan_q1      <= 1'b0;
         scan_q2      <= 1'b0;
         scan_q3      <= 1'b0;
         blink_q1     <= 1'b0;
         blink_q2     <= 1'b0;
         data_q       <= 16'h0;
         dp_mask_q    <= 4'h0;
         blink_mask_q <= 4'h0;
         lz_q         <= 1'b0;
         valid_q      <= 1'b0;
         seg_n_q      <= 7'h7F;
         dp_n_q       <= 1'b1;
         an_n_q       <= 4'hF;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         scan_q1      <= scan_clk;
         scan_q2      <= scan_q1;
         scan_q3      <= scan_q2;
         blink_q1     <= blink_clk;
         blink_q2     <= blink_q1;
         seg_n_q      <= seg_n_d;
         dp_n_q       <= dp_n_d;
         an_n_q       <= an_n_d;
         frame_done_q <= wrap;
         if (wrap) begin
            data_q       <= data_in;
            dp_mask_q    <= dp_mask;
            blink_mask_q <= blink_mask;
            lz_q         <= lz_en;
            valid_q      <= 1'b1;
         end
      end
   end

   assign seg_n      = seg_n_q;
   assign dp_n       = dp_n_q;
   assign an_n       = an_n_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_mux_7seg.sv
// tb/tb_display_mux_7seg.sv - self-checking bench for display_mux_7seg
module tb_display_mux_7seg;

   localparam int BC = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        scan_clk = 1'b0;
   logic        blink_clk = 1'b0;
   logic [15:0] data_in = 16'h0;
   logic [3:0]  dp_mask = 4'h0;
   logic [3:0]  blink_mask = 4'h0;
   logic        lz_en = 1'b0;
   logic [6:0]  seg_n, seg_n_h0;
   logic        dp_n, dp_n_h0;
   logic [3:0]  an_n, an_n_h0;
   logic        frame_done, frame_done_h0;

   display_mux_7seg #(.BLANK_CYCLES(BC), .HEX_MODE(1'b1), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .scan_clk(scan_clk), .blink_clk(blink_clk),
      .data_in(data_in), .dp_mask(dp_mask), .blink_mask(blink_mask), .lz_en(lz_en),
      .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n), .frame_done(frame_done));

   display_mux_7seg #(.BLANK_CYCLES(BC), .HEX_MODE(1'b0), .CNT_W(8)) dut_h0 (
      .clk(clk), .rst_n(rst_n), .scan_clk(scan_clk), .blink_clk(blink_clk),
      .data_in(data_in), .dp_mask(dp_mask), .blink_mask(blink_mask), .lz_en(lz_en),
      .seg_n(seg_n_h0), .dp_n(dp_n_h0), .an_n(an_n_h0), .frame_done(frame_done_h0));

   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic [6:0] seg_h0;
      logic       dp;
      logic [1:0] fdc;
   } slot_t;

   slot_t sb[$];
   logic  lit_q[$];

   // Reference model of what the display should show.
   int          m_idx;
   logic        m_valid, m_lz, m_blink_on, prev_lit;
   logic [15:0] m_data;
   logic [3:0]  m_dp, m_blink;

   function automatic logic [6:0] ref_seg(input logic [3:0] v, input logic hex);
      case (v)
         4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;
         4'h3: return 7'h30;  4'h4: return 7'h19;  4'h5: return 7'h12;
         4'h6: return 7'h02;  4'h7: return 7'h78;  4'h8: return 7'h00;
         4'h9: return 7'h10;
         4'hA: return hex ? 7'h08 : 7'h3F;  4'hB: return hex ? 7'h03 : 7'h3F;
         4'hC: return hex ? 7'h46 : 7'h3F;  4'hD: return hex ? 7'h21 : 7'h3F;
         4'hE: return hex ? 7'h06 : 7'h3F;  default: return hex ? 7'h0E : 7'h3F;
      endcase
   endfunction

   task automatic model_reset();
      m_idx = 0; m_valid = 1'b0; m_lz = 1'b0; m_data = 16'h0;
      m_dp = 4'h0; m_blink = 4'h0; prev_lit = 1'b0;
   endtask

   // Advance the model one scan step and push the expected slot.
   task automatic model_step();
      slot_t e;
      logic  lit, hide;
      logic [3:0] nib;
      m_idx = (m_idx + 1) % 4;
      e.fdc = 2'd0;
      if (m_idx == 0) begin
         m_data = data_in; m_dp = dp_mask; m_blink = blink_mask; m_lz = lz_en;
         m_valid = 1'b1; e.fdc = 2'd1;
      end
      hide = (m_idx != 0);
      for (int j = 0; j < 4; j++)
         if (j >= m_idx && m_data[4*j +: 4] != 4'h0) hide = 1'b0;
      lit = m_valid && !(m_lz && hide) && !(m_blink_on && m_blink[m_idx]);
      nib = m_data[4*m_idx +: 4];
      e.an     = lit ? ~(4'b0001 << m_idx) : 4'hF;
      e.seg    = lit ? ref_seg(nib, 1'b1) : 7'h7F;
      e.seg_h0 = lit ? ref_seg(nib, 1'b0) : 7'h7F;
      e.dp     = lit ? ~m_dp[m_idx] : 1'b1;
      sb.push_back(e);
      lit_q.push_back(lit);
   endtask

   // One scan period (40 clocks); returns the settled outputs, the number of
   // dark samples and the number of frame_done pulses seen.
   task automatic pulse(output slot_t o, output int offc);
      int fdc;
      offc = 0; fdc = 0;
      @(negedge clk) scan_clk = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (an_n === 4'hF) offc++;
         if (frame_done === 1'b1) fdc++;
         if (i == 20) scan_clk = 1'b0;
      end
      o.an = an_n; o.seg = seg_n; o.seg_h0 = seg_n_h0; o.dp = dp_n;
      o.fdc = (fdc > 3) ? 2'd3 : 2'(fdc);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({an_n, seg_n, dp_n, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0})
         $display("FAIL reset_state: got an=%b seg=%h dp=%b fd=%b want an=1111 seg=7f dp=1 fd=0",
                  an_n, seg_n, dp_n, frame_done);
      else passed++;
      rst_n = 1'b1;
      model_reset();
      repeat (20) @(negedge clk);
      total++;
      if ({an_n, seg_n, dp_n} !== {4'hF, 7'h7F, 1'b1})
         $display("FAIL idle_after_reset: got an=%b seg=%h dp=%b want off", an_n, seg_n, dp_n);
      else passed++;
   endtask

   task automatic test_sequence();
      slot_t o, e; int offc; logic lit;
      data_in = 16'h1234; lz_en = 1'b0; dp_mask = 4'h0; blink_mask = 4'h0;
      for (int k = 0; k < 12; k++) begin
         model_step(); pulse(o, offc);
         e = sb.pop_front(); lit = lit_q.pop_front();
         total++;
         if (o !== e) $display("FAIL seq_slot%0d: got %h want %h", k, o, e);
         else passed++;
         if (lit && prev_lit) begin
            total++;
            if (offc != BC + 1) $display("FAIL seq_dead%0d: got %0d want %0d", k, offc, BC + 1);
            else passed++;
         end
         prev_lit = lit;
      end
   endtask

   task automatic test_async_reset();
      total++;
      if (an_n !== 4'b1110) $display("FAIL pre_reset_drive: got an=%b want 1110", an_n);
      else passed++;
      @(negedge clk); #2 rst_n = 1'b0;
      #1;
      total++;
      if ({an_n, seg_n, dp_n} !== {4'hF, 7'h7F, 1'b1})
         $display("FAIL async_reset: got an=%b seg=%h dp=%b want off", an_n, seg_n, dp_n);
      else passed++;
      @(negedge clk) rst_n = 1'b1;
      model_reset();
      repeat (15) @(negedge clk);
      total++;
      if (an_n !== 4'hF) $display("FAIL post_reset_idle: got an=%b want 1111", an_n);
      else passed++;
   endtask

   task automatic test_lz();
      slot_t o, e; int offc;
      data_in = 16'h0005; lz_en = 1'b1;
      for (int k = 0; k < 12; k++) begin
         if (k == 8) data_in = 16'h0000;
         model_step(); pulse(o, offc);
         e = sb.pop_front(); prev_lit = lit_q.pop_front();
         total++;
         if (o !== e) $display("FAIL lz_slot%0d: got %h want %h", k, o, e);
         else passed++;
      end
   endtask

   task automatic test_hex();
      slot_t o, e; int offc;
      data_in = 16'hAF00; lz_en = 1'b0;
      for (int k = 0; k < 8; k++) begin
         model_step(); pulse(o, offc);
         e = sb.pop_front(); prev_lit = lit_q.pop_front();
         total++;
         if (o !== e) $display("FAIL hex_slot%0d: got %h want %h", k, o, e);
         else passed++;
      end
   endtask

   task automatic test_blink();
      slot_t o, e; int offc;
      data_in = 16'h1234; dp_mask = 4'b0001; blink_mask = 4'b0001;
      blink_clk = 1'b1; m_blink_on = 1'b1;
      repeat (5) @(negedge clk);
      for (int k = 0; k < 12; k++) begin
         if (k == 8) begin
            blink_clk = 1'b0; m_blink_on = 1'b0;
            repeat (5) @(negedge clk);
         end
         model_step(); pulse(o, offc);
         e = sb.pop_front(); prev_lit = lit_q.pop_front();
         total++;
         if (o !== e) $display("FAIL blink_slot%0d: got %h want %h", k, o, e);
         else passed++;
      end
   endtask

   task automatic test_midframe();
      slot_t o, e; int offc;
      dp_mask = 4'h0; blink_mask = 4'h0; data_in = 16'h5678;
      for (int k = 0; k < 9; k++) begin
         if (k > 4 && m_idx == 1) data_in = 16'h9ABC;
         model_step(); pulse(o, offc);
         e = sb.pop_front(); prev_lit = lit_q.pop_front();
         total++;
         if (o !== e) $display("FAIL mid_slot%0d: got %h want %h", k, o, e);
         else passed++;
      end
   endtask

   initial begin
      model_reset();
      m_blink_on = 1'b0;
      test_reset();
      test_sequence();
      test_async_reset();
      test_lz();
      test_hex();
      test_blink();
      test_midframe();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
